// File: rtl/amm_port_arbiter.sv
// Two-master Avalon-MM port arbiter: round-robin, write bursts held atomic,
// read responses routed back in order through a tag FIFO.
module amm_port_arbiter #(
  parameter int AMM_ADDR_W     = 31,
  parameter int AMM_DATA_W     = 128,
  parameter int AMM_BURST_W    = 11,
  parameter int RSP_FIFO_DEPTH = 8,
  localparam int DATA_B_W      = AMM_DATA_W / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   m0_read_i,
  input  logic                   m0_write_i,
  input  logic [AMM_ADDR_W-1:0]  m0_address_i,
  input  logic [AMM_DATA_W-1:0]  m0_writedata_i,
  input  logic [AMM_BURST_W-1:0] m0_burstcount_i,
  input  logic [DATA_B_W-1:0]    m0_byteenable_i,
  output logic                   m0_waitrequest_o,
  output logic                   m0_readdatavalid_o,
  output logic [AMM_DATA_W-1:0]  m0_readdata_o,
  input  logic                   m1_read_i,
  input  logic                   m1_write_i,
  input  logic [AMM_ADDR_W-1:0]  m1_address_i,
  input  logic [AMM_DATA_W-1:0]  m1_writedata_i,
  input  logic [AMM_BURST_W-1:0] m1_burstcount_i,
  input  logic [DATA_B_W-1:0]    m1_byteenable_i,
  output logic                   m1_waitrequest_o,
  output logic                   m1_readdatavalid_o,
  output logic [AMM_DATA_W-1:0]  m1_readdata_o,
  input  logic                   s_waitrequest_i,
  input  logic                   s_readdatavalid_i,
  input  logic [AMM_DATA_W-1:0]  s_readdata_i,
  output logic                   s_read_o,
  output logic                   s_write_o,
  output logic [AMM_ADDR_W-1:0]  s_address_o,
  output logic [AMM_DATA_W-1:0]  s_writedata_o,
  output logic [AMM_BURST_W-1:0] s_burstcount_o,
  output logic [DATA_B_W-1:0]    s_byteenable_o,
  output logic                   err_o
);

  localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_WR_BURST} state_t;

  // Master-side signals gathered into arrays so the mux indexes by grant
  logic [1:0]             m_read, m_write;
  logic [AMM_ADDR_W-1:0]  m_address    [2];
  logic [AMM_DATA_W-1:0]  m_writedata  [2];
  logic [AMM_BURST_W-1:0] m_burstcount [2];
  logic [DATA_B_W-1:0]    m_byteenable [2];

  assign m_read          = {m1_read_i, m0_read_i};
  assign m_write         = {m1_write_i, m0_write_i};
  assign m_address[0]    = m0_address_i;
  assign m_address[1]    = m1_address_i;
  assign m_writedata[0]  = m0_writedata_i;
  assign m_writedata[1]  = m1_writedata_i;
  assign m_burstcount[0] = m0_burstcount_i;
  assign m_burstcount[1] = m1_burstcount_i;
  assign m_byteenable[0] = m0_byteenable_i;
  assign m_byteenable[1] = m1_byteenable_i;

  state_t                 state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;
  logic [AMM_BURST_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [AMM_BURST_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic                   err_q, err_d;

  // Tag FIFO storage: issuing master id and normalised burst length
  logic                   fifo_id_q [RSP_FIFO_DEPTH];
  logic [AMM_BURST_W-1:0] fifo_bc_q [RSP_FIFO_DEPTH];

  logic                   sel_read, sel_write;
  logic [AMM_BURST_W-1:0] sel_bc;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop;
  logic                   head_id;
  logic [AMM_BURST_W-1:0] head_bc;
  logic [1:0]             wait_v;
  logic                   wr_acc, rd_acc;

  assign sel_read   = m_read[grant_q];
  assign sel_write  = m_write[grant_q];
  // A zero burstcount is treated as a single beat
  assign sel_bc     = (m_burstcount[grant_q] == '0) ? AMM_BURST_W'(1) : m_burstcount[grant_q];
  assign fifo_full  = (count_q == CNT_W'(RSP_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head_id    = fifo_id_q[rd_ptr_q];
  assign head_bc    = fifo_bc_q[rd_ptr_q];

  assign s_address_o    = m_address[grant_q];
  assign s_writedata_o  = m_writedata[grant_q];
  assign s_burstcount_o = m_burstcount[grant_q];
  assign s_byteenable_o = m_byteenable[grant_q];

  // Command strobes and stalls; write wins over a simultaneous read, and a
  // read is held off while the tag FIFO is full (judged on registered count)
  always_comb begin
    s_read_o  = 1'b0;
    s_write_o = 1'b0;
    wait_v    = 2'b11;
    case (state_q)
      ST_GRANT: begin
        s_write_o = sel_write;
        s_read_o  = sel_read & ~sel_write & ~fifo_full;
        wait_v[grant_q] = (sel_read & ~sel_write & fifo_full) ? 1'b1 : s_waitrequest_i;
      end
      ST_WR_BURST: begin
        s_write_o = sel_write;
        wait_v[grant_q] = s_waitrequest_i;
      end
      default: ;
    endcase
  end

  assign m0_waitrequest_o = wait_v[0];
  assign m1_waitrequest_o = wait_v[1];
  assign wr_acc = s_write_o & ~s_waitrequest_i;
  assign rd_acc = s_read_o & ~s_waitrequest_i;

  // Arbitration and burst tracking next-state
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    push         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((m_read | m_write) != 2'b00) begin
          if ((m_read | m_write) == 2'b11) grant_d = ~last_grant_q;
          else                             grant_d = m_read[1] | m_write[1];
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (wr_acc) begin
          beat_cnt_d = sel_bc - AMM_BURST_W'(1);
          if (sel_bc == AMM_BURST_W'(1)) begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_WR_BURST;
          end
        end else if (rd_acc) begin
          push         = 1'b1;
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end else if (!sel_read && !sel_write) begin
          // Granted master withdrew its request; rearbitrate
          state_d = ST_IDLE;
        end
      end
      ST_WR_BURST: begin
        if (wr_acc) begin
          beat_cnt_d = beat_cnt_q - AMM_BURST_W'(1);
          if (beat_cnt_q == AMM_BURST_W'(1)) begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response routing: beat count per head entry, pop on its final beat
  always_comb begin
    pop       = 1'b0;
    rsp_cnt_d = rsp_cnt_q;
    err_d     = err_q;
    if (s_readdatavalid_i) begin
      if (fifo_empty) begin
        err_d = 1'b1;
      end else if (rsp_cnt_q == head_bc - AMM_BURST_W'(1)) begin
        pop       = 1'b1;
        rsp_cnt_d = '0;
      end else begin
        rsp_cnt_d = rsp_cnt_q + AMM_BURST_W'(1);
      end
    end
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  assign m0_readdatavalid_o = s_readdatavalid_i & ~fifo_empty & ~head_id;
  assign m1_readdatavalid_o = s_readdatavalid_i & ~fifo_empty &  head_id;
  assign m0_readdata_o      = s_readdata_i;
  assign m1_readdata_o      = s_readdata_i;
  assign err_o              = err_q;

  // Control state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rsp_cnt_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rsp_cnt_q    <= rsp_cnt_d;
      err_q        <= err_d;
    end
  end

  // Tag FIFO write port; contents are only meaningful below count_q
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_id_q[wr_ptr_q] <= grant_q;
      fifo_bc_q[wr_ptr_q] <= sel_bc;
    end
  end

endmodule
